hex_scan_driver: RTL

- Upstream feeder for the hex7seg decoder. Holds a multi-digit hex word and time-multiplexes it, one nibble at a time, onto a single shared 7-segment bus with per-digit enables.
- Captures new display words through a load/ack handshake. Applies a captured word only at a frame boundary, so a frame never shows a mix of old and new digits.
- Inserts a blanking gap between digits to suppress ghosting. Sits between the SDES datapath result registers and the board's multiplexed display pins.

---
 rtl/hex_scan_driver_pkg.sv | 21 ++
 rtl/hex_scan_driver_hex7seg.sv | 33 +++
 rtl/hex_scan_driver.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hex_scan_driver_pkg.sv
// Shared types and helpers for the multiplexed hex display scanner.
// Holds the scan state encoding, the all-off segment pattern and the
// counter width helper used to size the dwell/gap counter.
package hex_scan_driver_pkg;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low segments: all ones means every segment is dark.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Bits needed to count 0..max(a,b)-1; never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hex_scan_driver_hex7seg.sv
// Hex nibble to active-low 7-segment decoder, segment order a..g = [0:6].
// Purely combinational, zero latency.
// No flow control; output follows the input.
module hex_scan_driver_hex7seg (
  input  logic [3:0] nibble_i,
  output logic [0:6] seg_o
);

  // Standard hex glyph table, 0 = segment lit.
  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexes a NUM_DIGITS hex word onto one shared 7-segment bus.
// Outputs are registered and describe the current scan slot; new words
// are staged in a pending register and applied only at a frame boundary.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 50000,
  parameter  int GAP_CYCLES   = 2,
  localparam int DATA_W       = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic                  load_ack,
  output logic                  pending,
  output logic                  frame_done,
  output logic [NUM_DIGITS-1:0] digit_en_n,
  output logic [0:6]            seg,
  output logic [3:0]            cur_nibble
);

  localparam int CW = cnt_width(DWELL_CYCLES, GAP_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  // The gap right after reset leads into digit 0 rather than following a
  // digit, so it must neither advance the index nor count as a boundary.
  logic                  start_gap_q, start_gap_d;
  logic [DATA_W-1:0]     active_q, active_d;
  logic [DATA_W-1:0]     pword_q, pword_d;
  logic                  pend_q, pend_d;
  logic                  boundary;

  logic                  ack_q;
  logic                  fd_q, fd_d;
  logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
  logic [0:6]            seg_q, seg_d;
  logic [3:0]            nib_q, nib_sel;
  logic [0:6]            hex_seg;
  logic                  show;

  // Scan sequencing plus the pending/active word handoff.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    start_gap_d = start_gap_q;
    active_d    = active_q;
    pword_d     = pword_q;
    pend_d      = pend_q;
    boundary    = 1'b0;
    case (state_q)
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d       = '0;
          state_d     = DRIVE;
          start_gap_d = 1'b0;
          if (!start_gap_q) begin
            boundary = (idx_q == IDX_LAST);
            idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = '0;
      end
    endcase
    // Transfer first so a same-cycle load lands in the freshly freed slot.
    if (boundary && pend_q) begin
      active_d = pword_q;
      pend_d   = 1'b0;
    end
    if (load) begin
      pword_d = data_in;
      pend_d  = 1'b1;
    end
  end

  assign nib_sel = active_d[{idx_d, 2'b00} +: 4];

  hex_scan_driver_hex7seg u_hex7seg (
    .nibble_i (nib_sel),
    .seg_o    (hex_seg)
  );

  // Output values for the slot being entered, so pins track the state.
  always_comb begin
    show   = (state_d == DRIVE) && !blank_mask[idx_d];
    en_n_d = '1;
    seg_d  = SEG_BLANK;
    if (show) begin
      en_n_d[idx_d] = 1'b0;
      seg_d         = hex_seg;
    end
    fd_d = (state_d == GAP) && (cnt_d == GAP_LAST) &&
           (idx_d == IDX_LAST) && !start_gap_d;
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= GAP;
      cnt_q       <= '0;
      idx_q       <= '0;
      start_gap_q <= 1'b1;
      active_q    <= '0;
      pword_q     <= '0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      fd_q        <= 1'b0;
      en_n_q      <= '1;
      seg_q       <= SEG_BLANK;
      nib_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      start_gap_q <= start_gap_d;
      active_q    <= active_d;
      pword_q     <= pword_d;
      pend_q      <= pend_d;
      ack_q       <= load;
      fd_q        <= fd_d;
      en_n_q      <= en_n_d;
      seg_q       <= seg_d;
      nib_q       <= nib_sel;
    end
  end

  assign load_ack   = ack_q;
  assign pending    = pend_q;
  assign frame_done = fd_q;
  assign digit_en_n = en_n_q;
  assign seg        = seg_q;
  assign cur_nibble = nib_q;

endmodule
